// File: rtl/md5_block_sequencer.sv
// Streams 512-bit blocks from the message RAM into the MD5 core and stores the resulting digests.
// Defining MD5_SEQ_TIMEOUT_EN enables a watchdog on the core done pulse.
module md5_block_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MSG_AW         = 9,
  parameter int DIG_AW         = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_start,
  input  logic              ctrl_abort,
  input  logic              ctrl_chain,
  input  logic [5:0]        ctrl_nblocks,
  output logic              ctrl_busy,
  output logic              ctrl_done,
  output logic              ctrl_error,
  output logic [5:0]        ctrl_blocks_done,
  output logic [MSG_AW-1:0] msg_raddr,
  input  logic [31:0]       msg_rdata,
  output logic              core_reset,
  output logic              core_start,
  output logic              core_chain,
  output logic [31:0]       core_word,
  output logic [3:0]        core_word_idx,
  output logic              core_word_valid,
  input  logic              core_done,
  input  logic [127:0]      core_digest,
  output logic [DIG_AW-1:0] dig_waddr,
  output logic [31:0]       dig_wdata,
  output logic              dig_we
);

`ifdef MD5_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FIRE, S_WAIT, S_WRITE, S_NEXT} state_t;

  state_t            state_q, state_d;
  logic              start_prev_q;
  logic              chain_q, chain_d;
  logic [5:0]        nblk_q, nblk_d;
  logic [4:0]        blk_q, blk_d;
  logic [4:0]        k_q, k_d;
  logic [31:0]       wcnt_q, wcnt_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [5:0]        bdone_q, bdone_d;
  logic              wvalid_q, wvalid_d;
  logic [3:0]        widx_q, widx_d;
  logic              cstart_q, cstart_d, cchain_q, cchain_d, creset_q, creset_d;
  logic              we_q, we_d;
  logic [DIG_AW-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [95:0]       dig_hi_q;

  logic start_edge, nblk_ok, last_blk, wr_needed, timeout_hit;

  function automatic logic [DIG_AW-1:0] dig_addr(input logic chain, input logic [4:0] blk,
                                                 input logic [1:0] i);
    return chain ? DIG_AW'(i) : DIG_AW'({blk, i});
  endfunction

  assign start_edge  = ctrl_start & ~start_prev_q;
  assign nblk_ok     = (ctrl_nblocks != 6'd0) && (ctrl_nblocks <= 6'd32);
  assign last_blk    = (({1'b0, blk_q} + 6'd1) == nblk_q);
  assign wr_needed   = !chain_q || last_blk;
  assign timeout_hit = TO_EN && ((wcnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));

  always_comb begin
    state_d  = state_q;
    chain_d  = chain_q;
    nblk_d   = nblk_q;
    blk_d    = blk_q;
    k_d      = k_q;
    wcnt_d   = wcnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    bdone_d  = bdone_q;
    wvalid_d = 1'b0;
    widx_d   = '0;
    cstart_d = 1'b0;
    cchain_d = 1'b0;
    creset_d = 1'b0;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge && !ctrl_abort) begin
          if (nblk_ok) begin
            chain_d = ctrl_chain;
            nblk_d  = ctrl_nblocks;
            done_d  = 1'b0;
            err_d   = 1'b0;
            bdone_d = '0;
            busy_d  = 1'b1;
            blk_d   = '0;
            k_d     = '0;
            state_d = S_FETCH;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        // RAM data lags the address by one cycle, so the valid strobe trails k by one.
        if (k_q < 5'd16) begin
          wvalid_d = 1'b1;
          widx_d   = k_q[3:0];
          k_d      = k_q + 5'd1;
        end else begin
          cstart_d = 1'b1;
          cchain_d = chain_q && (blk_q != 5'd0);
          state_d  = S_FIRE;
        end
      end
      S_FIRE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          if (wr_needed) begin
            we_d    = 1'b1;
            waddr_d = dig_addr(chain_q, blk_q, 2'd0);
            wdata_d = core_digest[31:0];
            k_d     = '0;
            state_d = S_WRITE;
          end else begin
            state_d = S_NEXT;
          end
        end else if (timeout_hit) begin
          creset_d = 1'b1;
          err_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 32'd1;
        end
      end
      S_WRITE: begin
        if (k_q == 5'd3) begin
          state_d = S_NEXT;
        end else begin
          we_d    = 1'b1;
          waddr_d = dig_addr(chain_q, blk_q, k_q[1:0] + 2'd1);
          wdata_d = dig_hi_q[{k_q[1:0], 5'd0} +: 32];
          k_d     = k_q + 5'd1;
        end
      end
      S_NEXT: begin
        bdone_d = bdone_q + 6'd1;
        if (last_blk) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          blk_d   = blk_q + 5'd1;
          k_d     = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything else, including a done pulse arriving in WAIT.
    if (ctrl_abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      creset_d = 1'b1;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      bdone_d  = bdone_q;
      wvalid_d = 1'b0;
      cstart_d = 1'b0;
      cchain_d = 1'b0;
      we_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      chain_q      <= 1'b0;
      nblk_q       <= '0;
      blk_q        <= '0;
      k_q          <= '0;
      wcnt_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      bdone_q      <= '0;
      wvalid_q     <= 1'b0;
      widx_q       <= '0;
      cstart_q     <= 1'b0;
      cchain_q     <= 1'b0;
      creset_q     <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= ctrl_start;
      chain_q      <= chain_d;
      nblk_q       <= nblk_d;
      blk_q        <= blk_d;
      k_q          <= k_d;
      wcnt_q       <= wcnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      bdone_q      <= bdone_d;
      wvalid_q     <= wvalid_d;
      widx_q       <= widx_d;
      cstart_q     <= cstart_d;
      cchain_q     <= cchain_d;
      creset_q     <= creset_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Word 0 goes out directly on the done cycle; only words 1..3 need holding.
  always_ff @(posedge clk) begin
    if (state_q == S_WAIT && core_done) dig_hi_q <= core_digest[127:32];
  end

  assign msg_raddr        = (state_q == S_FETCH && k_q < 5'd16) ? MSG_AW'({blk_q, k_q[3:0]}) : '0;
  assign core_word        = wvalid_q ? msg_rdata : 32'd0;
  assign core_word_valid  = wvalid_q;
  assign core_word_idx    = widx_q;
  assign core_start       = cstart_q;
  assign core_chain       = cchain_q;
  assign core_reset       = creset_q;
  assign dig_we           = we_q;
  assign dig_waddr        = waddr_q;
  assign dig_wdata        = wdata_q;
  assign ctrl_busy        = busy_q;
  assign ctrl_done        = done_q;
  assign ctrl_error       = err_q;
  assign ctrl_blocks_done = bdone_q;

endmodule

// File: tb/tb_md5_block_sequencer.sv
// Scoreboard bench for md5_block_sequencer: stimulus queues expected core/digest traffic,
// a negedge monitor pops and compares each strobe the DUT presents.
module tb_md5_block_sequencer;
  localparam int CORE_LAT = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         ctrl_start, ctrl_abort, ctrl_chain;
  logic [5:0]   ctrl_nblocks;
  logic         ctrl_busy, ctrl_done, ctrl_error;
  logic [5:0]   ctrl_blocks_done;
  logic [8:0]   msg_raddr;
  logic [31:0]  msg_rdata;
  logic         core_reset, core_start, core_chain;
  logic [31:0]  core_word;
  logic [3:0]   core_word_idx;
  logic         core_word_valid;
  logic         core_done;
  logic [127:0] core_digest;
  logic [6:0]   dig_waddr;
  logic [31:0]  dig_wdata;
  logic         dig_we;

  md5_block_sequencer #(.TIMEOUT_CYCLES(100), .MSG_AW(9), .DIG_AW(7)) dut (
    .clk(clk), .reset(reset),
    .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort), .ctrl_chain(ctrl_chain),
    .ctrl_nblocks(ctrl_nblocks), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
    .ctrl_error(ctrl_error), .ctrl_blocks_done(ctrl_blocks_done),
    .msg_raddr(msg_raddr), .msg_rdata(msg_rdata),
    .core_reset(core_reset), .core_start(core_start), .core_chain(core_chain),
    .core_word(core_word), .core_word_idx(core_word_idx), .core_word_valid(core_word_valid),
    .core_done(core_done), .core_digest(core_digest),
    .dig_waddr(dig_waddr), .dig_wdata(dig_wdata), .dig_we(dig_we)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] idx; logic [31:0] w; } wexp_t;
  typedef struct { logic [6:0] a;   logic [31:0] d; } dexp_t;
  wexp_t exp_w[$];
  bit    exp_f[$];
  dexp_t exp_d[$];
  int    exp_rst[$];

  function automatic logic [31:0] memw(input int a);
    return 32'h5A00_0000 | 32'(a);
  endfunction
  function automatic logic [31:0] digw(input int n, input int i);
    return 32'hD100_0000 + 32'(n) * 32'd256 + 32'(i);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Message RAM: synchronous read, one cycle latency
  logic [31:0] mem [512];
  initial for (int a = 0; a < 512; a++) mem[a] = memw(a);
  always @(posedge clk) msg_rdata <= mem[msg_raddr];

  // Core model: done pulse CORE_LAT cycles after start, digest encodes the fire number
  logic core_hang = 1'b0;
  logic armed;
  int   cnt, fire_no;
  always @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0; cnt <= 0; fire_no <= 0; core_done <= 1'b0; core_digest <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_reset) begin
        armed <= 1'b0; cnt <= 0;
      end else if (core_start) begin
        armed <= 1'b1; cnt <= 1; fire_no <= fire_no + 1;
      end else if (armed && !core_hang) begin
        if (cnt == CORE_LAT - 1) begin
          core_done   <= 1'b1;
          armed       <= 1'b0;
          core_digest <= {digw(fire_no, 3), digw(fire_no, 2), digw(fire_no, 1), digw(fire_no, 0)};
        end else cnt <= cnt + 1;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin : mon
    wexp_t ew;
    dexp_t ed;
    bit    ef;
    if (!reset) begin
      if (core_word_valid) begin
        if (exp_w.size() == 0) chk("word_unexpected", 1, 0);
        else begin
          ew = exp_w.pop_front();
          chk("word_idx", 64'(core_word_idx), 64'(ew.idx));
          chk("word_data", 64'(core_word), 64'(ew.w));
        end
      end
      if (core_start) begin
        if (exp_f.size() == 0) chk("fire_unexpected", 1, 0);
        else begin
          ef = exp_f.pop_front();
          chk("fire_chain", 64'(core_chain), 64'(ef));
        end
      end
      if (dig_we) begin
        if (exp_d.size() == 0) chk("dig_unexpected", 1, 0);
        else begin
          ed = exp_d.pop_front();
          chk("dig_addr", 64'(dig_waddr), 64'(ed.a));
          chk("dig_data", 64'(dig_wdata), 64'(ed.d));
        end
      end
      if (core_reset) begin
        if (exp_rst.size() == 0) chk("core_reset_unexpected", 1, 0);
        else void'(exp_rst.pop_front());
      end
    end
  end

  task automatic push_blk(input int b, input bit chain_bit, input bit write, input bit chained,
                          input int fire_n);
    wexp_t ew;
    dexp_t ed;
    for (int i = 0; i < 16; i++) begin
      ew.idx = 4'(i);
      ew.w   = memw(b * 16 + i);
      exp_w.push_back(ew);
    end
    exp_f.push_back(chain_bit);
    if (write)
      for (int i = 0; i < 4; i++) begin
        ed.a = chained ? 7'(i) : 7'(b * 4 + i);
        ed.d = digw(fire_n, i);
        exp_d.push_back(ed);
      end
  endtask

  task automatic push_job(input int nblk, input bit chained, input int first_fire);
    for (int b = 0; b < nblk; b++)
      push_blk(b, chained && b != 0, !chained || b == nblk - 1, chained, first_fire + b);
  endtask

  task automatic drain_check(input string nm);
    chk(nm, 64'(exp_w.size() + exp_f.size() + exp_d.size() + exp_rst.size()), 0);
    exp_w.delete(); exp_f.delete(); exp_d.delete(); exp_rst.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ctrl_start = 1'b0; ctrl_abort = 1'b0; ctrl_chain = 1'b0; ctrl_nblocks = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int max, input string nm);
    int n = 0;
    while (!ctrl_done && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(ctrl_done), 1);
  endtask

  initial begin
    int lows;
    int nbv [2];
    reset = 1'b1;
    ctrl_start = 1'b0; ctrl_abort = 1'b0; ctrl_chain = 1'b0; ctrl_nblocks = '0;

    // Reset state
    do_reset();
    chk("rst_status", 64'({ctrl_busy, ctrl_done, ctrl_error, ctrl_blocks_done}), 0);
    chk("rst_strobes", 64'({core_reset, core_start, core_chain, core_word_valid, dig_we}), 0);
    chk("rst_buses", 64'({msg_raddr, dig_waddr, core_word_idx}), 0);
    chk("rst_data", {core_word, dig_wdata}, 0);

    // Independent, two blocks
    push_job(2, 1'b0, 1);
    ctrl_nblocks = 6'd2; ctrl_chain = 1'b0; ctrl_start = 1'b1;
    @(negedge clk);
    chk("ind_busy", 64'(ctrl_busy), 1);
    wait_done(600, "ind_done_seen");
    chk("ind_final", 64'({ctrl_busy, ctrl_done, ctrl_error, ctrl_blocks_done}), 64'({3'b010, 6'd2}));
    ctrl_start = 1'b0;
    @(negedge clk);
    drain_check("ind_leftover");

    // Chained, three blocks
    do_reset();
    push_job(3, 1'b1, 1);
    ctrl_nblocks = 6'd3; ctrl_chain = 1'b1; ctrl_start = 1'b1;
    wait_done(800, "chain_done_seen");
    chk("chain_final", 64'({ctrl_busy, ctrl_done, ctrl_error, ctrl_blocks_done}), 64'({3'b010, 6'd3}));
    ctrl_start = 1'b0;
    @(negedge clk);
    drain_check("chain_leftover");

    // Bad block counts
    nbv[0] = 0; nbv[1] = 40;
    foreach (nbv[j]) begin
      do_reset();
      ctrl_nblocks = 6'(nbv[j]); ctrl_start = 1'b1;
      chk("bad_pre", 64'({ctrl_error, ctrl_done}), 0);
      @(negedge clk);
      chk("bad_err", 64'({ctrl_error, ctrl_done, ctrl_busy}), 64'(3'b110));
      repeat (10) @(negedge clk);
      ctrl_start = 1'b0;
      chk("bad_sticky", 64'({ctrl_error, ctrl_done, ctrl_busy}), 64'(3'b110));
      drain_check("bad_leftover");
    end

    // Abort and start edge together in IDLE
    do_reset();
    ctrl_nblocks = 6'd1; ctrl_abort = 1'b1; ctrl_start = 1'b1;
    @(negedge clk);
    chk("abst_busy", 64'(ctrl_busy), 0);
    repeat (3) @(negedge clk);
    ctrl_abort = 1'b0; ctrl_start = 1'b0;
    @(negedge clk);
    chk("abst_status", 64'({ctrl_busy, ctrl_done, ctrl_error}), 0);
    drain_check("abst_leftover");

    // Abort in the same cycle as block 1's core_done
    do_reset();
    push_blk(0, 1'b0, 1'b1, 1'b0, 1);
    push_blk(1, 1'b0, 1'b0, 1'b0, 2);
    ctrl_nblocks = 6'd2; ctrl_chain = 1'b0; ctrl_start = 1'b1;
    begin : find_done
      int n = 0;
      while (!(core_done && fire_no == 2) && n < 600) begin
        @(negedge clk);
        n++;
      end
    end
    chk("abort_sync_found", 64'(core_done), 1);
    ctrl_abort = 1'b1;
    exp_rst.push_back(1);
    @(negedge clk);
    ctrl_abort = 1'b0;
    chk("abort_status", 64'({ctrl_busy, ctrl_done, ctrl_error, ctrl_blocks_done}), 64'({3'b000, 6'd1}));
    repeat (10) @(negedge clk);
    chk("abort_hold", 64'({ctrl_busy, ctrl_done, ctrl_blocks_done}), 64'({2'b00, 6'd1}));
    ctrl_start = 1'b0;
    drain_check("abort_leftover");

    // Start held / re-edged while busy, then a fresh job after done
    do_reset();
    push_job(1, 1'b0, 1);
    ctrl_nblocks = 6'd1; ctrl_chain = 1'b0; ctrl_start = 1'b1;
    repeat (30) @(negedge clk);
    ctrl_start = 1'b0;
    @(negedge clk);
    ctrl_start = 1'b1;
    @(negedge clk);
    chk("held_busy", 64'(ctrl_busy), 1);
    wait_done(400, "held_done_seen");
    repeat (5) @(negedge clk);
    chk("held_final", 64'({ctrl_busy, ctrl_done, ctrl_blocks_done}), 64'({2'b01, 6'd1}));
    drain_check("held_leftover");
    ctrl_start = 1'b0;
    @(negedge clk);
    push_job(1, 1'b0, 2);
    ctrl_start = 1'b1;
    @(negedge clk);
    chk("restart_clears", 64'({ctrl_busy, ctrl_done, ctrl_blocks_done}), 64'({2'b10, 6'd0}));
    wait_done(400, "restart_done_seen");
    chk("restart_final", 64'({ctrl_busy, ctrl_done, ctrl_blocks_done}), 64'({2'b01, 6'd1}));
    ctrl_start = 1'b0;
    @(negedge clk);
    drain_check("restart_leftover");

    // Core never finishes
    do_reset();
    core_hang = 1'b1;
    push_blk(0, 1'b0, 1'b0, 1'b0, 1);
    ctrl_nblocks = 6'd1; ctrl_chain = 1'b0; ctrl_start = 1'b1;
`ifdef MD5_SEQ_TIMEOUT_EN
    begin : to_blk
      int n = 0;
      int t0;
      while (!core_start && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("to_fire_seen", 64'(core_start), 1);
      t0 = cyc;
      exp_rst.push_back(1);
      n = 0;
      while (!core_reset && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("to_delay", 64'(cyc - t0), 101);
      chk("to_status", 64'({core_reset, ctrl_error, ctrl_done, ctrl_busy}), 64'(4'b1110));
    end
`else
    lows = 0;
    repeat (10000) begin
      @(negedge clk);
      if (!ctrl_busy) lows++;
    end
    chk("hang_busy_lows", 64'(lows), 0);
    exp_rst.push_back(1);
    ctrl_abort = 1'b1;
    @(negedge clk);
    ctrl_abort = 1'b0;
    chk("hang_abort_status", 64'({ctrl_busy, ctrl_done, ctrl_error}), 0);
`endif
    ctrl_start = 1'b0;
    core_hang = 1'b0;
    repeat (3) @(negedge clk);
    drain_check("hang_leftover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
